// File: rtl/keypad_dispatcher_if.sv
// Two outbound key-event channels (stopwatch and calculator) with valid/ready handshake.
interface keypad_dispatcher_if;
  logic       cron_valid;
  logic [4:0] cron_key;
  logic       cron_ready;
  logic       calc_valid;
  logic [4:0] calc_key;
  logic       calc_ready;

  modport master (output cron_valid, cron_key, calc_valid, calc_key,
                  input  cron_ready, calc_ready);
  modport slave  (input  cron_valid, cron_key, calc_valid, calc_key,
                  output cron_ready, calc_ready);
endinterface

// File: rtl/keypad_dispatcher.sv
// Debounces a raw keypad code, queues press events and routes them to the
// stopwatch or calculator channel depending on the current mode.
module keypad_dispatcher #(
  parameter int         DEB    = 20,
  parameter logic [4:0] T_NULL = 5'd31,
  parameter logic [4:0] T_HASH = 5'd14,
  parameter logic [4:0] T_ASTE = 5'd15,
  parameter logic [4:0] T_D    = 5'd13,
  parameter int         DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           key,
  keypad_dispatcher_if.master  ch,
  output logic                 modo_atual,
  output logic [2:0]           fifo_count,
  output logic                 drop
);
  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW      = $clog2(DEB + 1);
  localparam logic [CW-1:0]   CNT_TOP = CW'(DEB - 1);
  localparam logic [2:0]      FULL    = 3'(DEPTH);
  localparam logic [AW-1:0]   PTR_TOP = AW'(DEPTH - 1);

  typedef enum logic {CRON = 1'b0, CALC = 1'b1} mode_t;
  mode_t mode;

  logic [4:0]    key_q;
  logic [CW-1:0] cnt;
  logic          armed, stable, press;

  // stable: key_q has matched the raw input for DEB consecutive samples
  assign stable = (key == key_q) && (cnt == CNT_TOP);
  assign press  = armed && stable && (key_q != T_NULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= T_NULL;
      cnt   <= '0;
      armed <= 1'b1;
    end else begin
      key_q <= key;
      if (key != key_q)        cnt <= '0;
      else if (cnt != CNT_TOP) cnt <= cnt + 1'b1;
      if (press)                            armed <= 1'b0;
      else if (stable && key_q == T_NULL)   armed <= 1'b1;
    end
  end

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic [2:0]    count;
  logic [4:0]    head;
  logic          sw_pop, fwd, cv, av, pop, push;

  assign head = mem[rd];

  always_comb begin
    sw_pop = 1'b0;
    fwd    = 1'b0;
    if (count != 3'd0) begin
      if (mode == CRON && (head == T_HASH || head == T_ASTE)) sw_pop = 1'b1;
      else if (mode == CALC && head == T_D)                   sw_pop = 1'b1;
      else                                                    fwd    = 1'b1;
    end
  end

  assign cv   = fwd && (mode == CRON);
  assign av   = fwd && (mode == CALC);
  assign pop  = sw_pop || (cv && ch.cron_ready) || (av && ch.calc_ready);
  // a full queue still takes the new event if the head leaves on the same edge
  assign push = press && ((count != FULL) || pop);

  assign ch.cron_valid = cv;
  assign ch.cron_key   = cv ? head : T_NULL;
  assign ch.calc_valid = av;
  assign ch.calc_key   = av ? head : T_NULL;

  always_ff @(posedge clk) begin
    if (push) mem[wr] <= key_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
      drop  <= 1'b0;
      mode  <= CRON;
    end else begin
      if (push) wr <= (wr == PTR_TOP) ? '0 : wr + 1'b1;
      if (pop)  rd <= (rd == PTR_TOP) ? '0 : rd + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (press && !push) drop <= 1'b1;
      if (sw_pop) mode <= (mode == CRON) ? CALC : CRON;
    end
  end

  assign modo_atual = mode;
  assign fifo_count = count;
endmodule

// File: doc/keypad_dispatcher.md
KEYPAD_DISPATCHER -- requirements
Module: keypad_dispatcher

Interface
REQ-001 Parameter DEB, default 20, is the number of consecutive stable samples (ms at 1 kHz) required to accept a key.
REQ-002 Parameter T_NULL, default 5'd31, is the no-key code.
REQ-003 Parameter T_HASH, default 5'd14, is the '#' code; T_ASTE, default 5'd15, is the '*' code; T_D, default 5'd13, is the 'D' code.
REQ-004 Parameter DEPTH, default 4, is the event FIFO depth (power of two).
REQ-005 clk  input  1  single clock, 1 kHz; all state updates on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 key  input  5  raw keypad code, T_NULL when idle.
REQ-008 cron_valid / cron_key / cron_ready  output / output / input  1/5/1  event channel to the stopwatch.
REQ-009 calc_valid / calc_key / calc_ready  output / output / input  1/5/1  event channel to the calculator.
REQ-010 modo_atual  output  1  current mode, 0 = CRON, 1 = CALC.
REQ-011 fifo_count  output  3  number of queued events (0..DEPTH).
REQ-012 drop  output  1  sticky flag: an accepted press was lost because the FIFO was full.

Function
REQ-013 key SHALL be registered once (key_q) before any use; the stability counter SHALL reset to 0 whenever key differs from key_q.
REQ-014 A press event SHALL be generated once, on the edge where key_q != T_NULL has been stable for DEB samples and the detector is armed.
REQ-015 The detector SHALL disarm on a press event and re-arm only after key_q == T_NULL has been stable for DEB samples; a held key or a direct change to another non-null code SHALL NOT generate a second event.
REQ-016 A press event SHALL be pushed into the FIFO on the same edge it is generated.
REQ-017 A push SHALL be accepted when fifo_count < DEPTH, or when fifo_count == DEPTH and a pop occurs on the same edge; otherwise the event is discarded and drop SHALL be set.
REQ-018 Mode FSM states: CRON, CALC; the head entry of the FIFO is processed as follows.
REQ-019 In CRON, a head of T_HASH or T_ASTE SHALL be popped without being forwarded, with modo_atual going to CALC on the same edge (1 cycle).
REQ-020 In CALC, a head of T_D SHALL be popped without being forwarded, with modo_atual going to CRON on the same edge (1 cycle).
REQ-021 Any other head SHALL be presented only on the channel of the current mode: valid = 1, key = head code; the other channel's valid SHALL be 0.
REQ-022 A presented head SHALL be popped on the edge where valid && ready; valid and key SHALL stay stable until that edge.
REQ-023 A channel's key output SHALL be T_NULL whenever its valid is 0.
REQ-024 Latency: with an empty FIFO and an armed detector, a key held constant from cycle 0 SHALL produce valid (or a mode change) in cycle DEB+1.
REQ-025 Throughput: one pop per cycle is allowed; back-to-back queued events SHALL be presented in consecutive cycles when ready stays high.
REQ-026 Ordering: events SHALL leave the FIFO in press order; a mode-switch key SHALL affect only entries queued behind it.
REQ-027 fifo_count SHALL increment on a push-only edge, decrement on a pop-only edge, and hold when both occur; the pointers SHALL wrap modulo DEPTH.

Reset
REQ-028 While rst_n == 0: modo_atual = CRON, cron_valid = calc_valid = 0, cron_key = calc_key = T_NULL, fifo_count = 0, drop = 0, key_q = T_NULL, counter = 0, detector armed.
REQ-029 Reset assertion mid-handshake SHALL discard all queued events immediately; the first press after release SHALL require the full DEB samples.

Verification
REQ-030 Press '5' (5'd5) for 30 cycles in CRON with cron_ready = 1 -> cron_valid high for exactly 1 cycle at cycle 21 with cron_key = 5; calc_valid stays 0; only one event.
REQ-031 Glitch: key = 5 for 19 cycles, then T_NULL -> no event; fifo_count stays 0.
REQ-032 In CRON, press T_HASH, release, then press 7 -> modo_atual = 1 and no cron_valid; 7 appears on calc_valid/calc_key; then press T_D -> modo_atual = 0 with no calc_valid.
REQ-033 With cron_ready = 0, perform 5 distinct presses -> fifo_count = 4, drop = 1; raise ready -> 4 events are forwarded in press order in 4 consecutive cycles, and drop stays 1.
REQ-034 With FIFO full and ready = 1, a press completing on the pop edge -> accepted, fifo_count stays 4, drop stays 0.
REQ-035 Queue 3 events and assert rst_n = 0 for 1 cycle -> all outputs at reset values, and fifo_count = 0 after release.
